pad_streamer: RTL and testbench

Raster pixel source that feeds the 3x3 convolution line-buffer chain. Consumes an unpadded feature-map stream (W x H words of 64 bits, 8 channels x 8 bits) over a valid/ready handshake and emits a zero-padded (W+2) x (H+2) raster stream with a registered valid/ready output. Also publishes the padded line width the line buffers use as their circular length. Sits between the input DMA unpacker and the first line buffer of each conv layer.

---
 rtl/pad_streamer.sv | 191 +++++++++++++++++++
 tb/tb_pad_streamer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pad_streamer.sv
// pad_streamer: wraps an unpadded W x H pixel stream in a one-pixel zero border,
// producing a (W+2) x (H+2) raster for the 3x3 convolution line-buffer chain.
// Optional macro PAD_STREAMER_DRAIN_EN appends one extra zero row (DRAIN) that
// flushes the last stencil window through the downstream pipeline.
module pad_streamer #(
    parameter int DATA_W = 64,
    parameter int DIM_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DIM_W-1:0]  cfg_width,
    input  logic [DIM_W-1:0]  cfg_height,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_pixel,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic [31:0]       line_width,
    output logic              busy,
    output logic              done
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_PAD_TOP = 3'd1;
    localparam logic [2:0] S_BODY    = 3'd2;
    localparam logic [2:0] S_PAD_BOT = 3'd3;
`ifdef PAD_STREAMER_DRAIN_EN
    localparam logic [2:0] S_DRAIN   = 3'd4;
`endif
    localparam logic [2:0] S_DONE    = 3'd5;

    localparam logic [DIM_W:0] CNT_ONE = (DIM_W+1)'(1);

    logic [2:0]       state;
    logic [DIM_W-1:0] width_q;
    logic [DIM_W-1:0] height_q;
    logic [DIM_W:0]   col;
    logic [DIM_W:0]   row;
    logic [DIM_W:0]   last_col;
    logic             at_last_col;
    logic             last_body_row;
    logic             interior;
    logic             slot_free;
    logic             emit;
    logic             final_pixel;

    // Counters are one bit wider than the configured size so W+1 / H+1 fit.
    assign last_col      = {1'b0, width_q} + CNT_ONE;
    assign at_last_col   = (col == last_col);
    assign last_body_row = (row == {1'b0, height_q});
    assign interior      = (col != '0) && !at_last_col;
    assign slot_free     = !out_valid || out_ready;

    // Only interior body columns consume input, and only when the output slot can take it.
    assign in_ready = (state == S_BODY) && interior && slot_free;

`ifdef PAD_STREAMER_DRAIN_EN
    assign final_pixel = (state == S_DRAIN) && at_last_col;
`else
    assign final_pixel = (state == S_PAD_BOT) && at_last_col;
`endif

    // Decide whether a new pixel enters the output register this cycle.
    always_comb begin
        emit = 1'b0;
        if (slot_free) begin
            case (state)
                S_PAD_TOP: emit = 1'b1;
                S_BODY:    emit = !interior || in_valid;
                S_PAD_BOT: emit = 1'b1;
`ifdef PAD_STREAMER_DRAIN_EN
                S_DRAIN:   emit = 1'b1;
`endif
                default:   emit = 1'b0;
            endcase
        end
    end

    // Registered output stage: load a new pixel, drop valid on a bubble, or hold during a stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_pixel <= '0;
            out_last  <= 1'b0;
        end else if (emit) begin
            out_valid <= 1'b1;
            out_pixel <= ((state == S_BODY) && interior) ? in_data : '0;
            out_last  <= final_pixel;
        end else if (slot_free) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

    // Frame sequencer: walks the padded raster column by column, row by row.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            width_q    <= '0;
            height_q   <= '0;
            col        <= '0;
            row        <= '0;
            line_width <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        width_q    <= cfg_width;
                        height_q   <= cfg_height;
                        line_width <= {{(32-DIM_W){1'b0}}, cfg_width} + 32'd2;
                        col        <= '0;
                        row        <= '0;
                        busy       <= 1'b1;
                        if ((cfg_width == '0) || (cfg_height == '0)) begin
                            state <= S_DONE;
                        end else begin
                            state <= S_PAD_TOP;
                        end
                    end
                end
                S_PAD_TOP: begin
                    if (emit) begin
                        if (at_last_col) begin
                            col   <= '0;
                            row   <= row + CNT_ONE;
                            state <= S_BODY;
                        end else begin
                            col <= col + CNT_ONE;
                        end
                    end
                end
                S_BODY: begin
                    if (emit) begin
                        if (at_last_col) begin
                            col <= '0;
                            row <= row + CNT_ONE;
                            if (last_body_row) begin
                                state <= S_PAD_BOT;
                            end
                        end else begin
                            col <= col + CNT_ONE;
                        end
                    end
                end
                S_PAD_BOT: begin
                    if (emit) begin
                        if (at_last_col) begin
                            col <= '0;
                            row <= row + CNT_ONE;
`ifdef PAD_STREAMER_DRAIN_EN
                            state <= S_DRAIN;
`else
                            state <= S_DONE;
`endif
                        end else begin
                            col <= col + CNT_ONE;
                        end
                    end
                end
`ifdef PAD_STREAMER_DRAIN_EN
                S_DRAIN: begin
                    if (emit) begin
                        if (at_last_col) begin
                            col   <= '0;
                            state <= S_DONE;
                        end else begin
                            col <= col + CNT_ONE;
                        end
                    end
                end
`endif
                S_DONE: begin
                    // Wait for the final pixel to leave before signalling completion.
                    if (slot_free) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pad_streamer.sv
// tb_pad_streamer: self-checking bench for pad_streamer. Expected raster is built
// from the padding rule (border zeros around the W x H input, optional drain row).
`timescale 1ns/1ps
module tb_pad_streamer;

`ifdef PAD_STREAMER_DRAIN_EN
    localparam int DR = 1;
`else
    localparam int DR = 0;
`endif

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] cfg_width;
    logic [15:0] cfg_height;
    logic [63:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] out_pixel;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic [31:0] line_width;
    logic        busy;
    logic        done;

    int compared;
    int mismatched;

    typedef struct {
        logic [63:0] pix;
        logic        last;
    } exp_t;

    typedef struct {
        int w;
        int h;
        int vpct;
        int rpct;
        bit seqdata;
        int exp_count;
    } vec_t;

    exp_t        exp_q[$];
    logic [63:0] src[$];

    pad_streamer #(.DATA_W(64), .DIM_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .cfg_width  (cfg_width),
        .cfg_height (cfg_height),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_pixel  (out_pixel),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .line_width (line_width),
        .busy       (busy),
        .done       (done)
    );

    // 100 MHz clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something hangs outside the per-frame cycle budgets
    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Build the expected padded raster from W, H and the input words
    task automatic buildModel(input int w, input int h, input bit seqdata);
        int rows;
        exp_t e;
        src.delete();
        exp_q.delete();
        for (int i = 0; i < w * h; i++) begin
            src.push_back(seqdata ? 64'(i + 1) : {$urandom, $urandom});
        end
        if (w > 0 && h > 0) begin
            rows = h + 2 + DR;
            for (int r = 0; r < rows; r++) begin
                for (int c = 0; c < w + 2; c++) begin
                    if (r >= 1 && r <= h && c >= 1 && c <= w) e.pix = src[(r - 1) * w + (c - 1)];
                    else e.pix = 64'd0;
                    e.last = (r == rows - 1) && (c == w + 1);
                    exp_q.push_back(e);
                end
            end
        end
    endtask

    // Run one frame. vpct<0: in_valid only after 5 idle cycles; rpct<0: out_ready toggles 1,0.
    task automatic applyStimulus(input int w, input int h, input int vpct, input int rpct,
                                 input bit seqdata, input int abort_after, input int restart_at,
                                 output int n_out);
        int   idx, gap, k, last_hs, budget;
        bit   finished, aborted, got_done, stalled_prev, prev_last;
        logic [63:0] prev_pix;
        exp_t e;
        buildModel(w, h, seqdata);
        idx = 0; gap = 0; n_out = 0; last_hs = 0;
        finished = 0; aborted = 0; got_done = 0; stalled_prev = 0;
        prev_pix = '0; prev_last = 0;
        budget = 40 * (exp_q.size() + 10) + 100;

        @(posedge clk); #1;
        start = 1'b1; cfg_width = 16'(w); cfg_height = 16'(h);
        in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;

        k = 0;
        while (!finished && k < budget) begin
            if (k == restart_at) begin
                start = 1'b1; cfg_width = 16'(w + 3); cfg_height = 16'(h + 1);
            end else begin
                start = 1'b0; cfg_width = 16'(w); cfg_height = 16'(h);
            end
            if (rpct < 0) out_ready = (k % 2 == 0);
            else out_ready = ($urandom_range(0, 99) < rpct);
            if (vpct < 0) in_valid = (gap >= 5);
            else in_valid = ($urandom_range(0, 99) < vpct);
            in_data = (idx < src.size()) ? src[idx] : 64'hA5A5_5A5A_0F0F_F0F0;
            #1;
            if (k == 0) begin
                checkOutput("busy_after_start", 64'(busy), 64'd1);
                checkOutput("line_width", 64'(line_width), 64'(w + 2));
                checkOutput("valid_first_cycle", 64'(out_valid), 64'd0);
            end
            if (k == 1 && w > 0 && h > 0) checkOutput("valid_second_cycle", 64'(out_valid), 64'd1);
            if (done) begin
                got_done = 1;
                finished = 1;
                checkOutput("done_cycle", 64'(k), 64'(last_hs + 1));
                checkOutput("busy_at_done", 64'(busy), 64'd0);
            end else begin
                if (stalled_prev) begin
                    checkOutput("hold_valid", 64'(out_valid), 64'd1);
                    checkOutput("hold_pixel", out_pixel, prev_pix);
                    checkOutput("hold_last", 64'(out_last), 64'(prev_last));
                end
                if (out_valid && !out_ready) checkOutput("in_ready_blocked", 64'(in_ready), 64'd0);
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checkOutput("extra_output", 64'd1, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("pixel", out_pixel, e.pix);
                        checkOutput("last", 64'(out_last), 64'(e.last));
                    end
                    n_out++;
                    last_hs = k;
                    if (abort_after > 0 && n_out == abort_after) begin
                        aborted = 1;
                        finished = 1;
                    end
                end
                if (in_valid && in_ready) begin
                    idx++;
                    gap = 0;
                end else if (!in_valid) begin
                    gap++;
                end
                stalled_prev = out_valid && !out_ready;
                prev_pix = out_pixel;
                prev_last = out_last;
            end
            if (!finished) begin
                @(posedge clk); #1;
                k++;
            end
        end
        start = 1'b0; cfg_width = 16'(w); cfg_height = 16'(h);

        if (aborted) begin
            @(posedge clk); #1;
            rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
            @(posedge clk); #1;
            rst = 1'b0; #1;
            checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
            checkOutput("rst_out_pixel", out_pixel, 64'd0);
            checkOutput("rst_out_last", 64'(out_last), 64'd0);
            checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
            checkOutput("rst_busy", 64'(busy), 64'd0);
            checkOutput("rst_done", 64'(done), 64'd0);
            checkOutput("rst_line_width", 64'(line_width), 64'd0);
            repeat (5) begin
                @(posedge clk); #2;
                checkOutput("no_done_after_rst", 64'(done), 64'd0);
            end
        end else begin
            if (!got_done) checkOutput("done_timeout", 64'd0, 64'd1);
            checkOutput("model_drained", 64'(exp_q.size()), 64'd0);
            if (restart_at >= 0) checkOutput("line_width_kept", 64'(line_width), 64'(w + 2));
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
    endtask

    vec_t vecs[7];

    initial begin
        int n;
        int rw, rh, rexp;
        compared = 0;
        mismatched = 0;

        vecs[0] = '{w: 2, h: 2, vpct: 100, rpct: 100, seqdata: 1, exp_count: 4 * (4 + DR)};
        vecs[1] = '{w: 2, h: 2, vpct: 100, rpct: -1,  seqdata: 1, exp_count: 4 * (4 + DR)};
        vecs[2] = '{w: 3, h: 1, vpct: -1,  rpct: 100, seqdata: 1, exp_count: 5 * (3 + DR)};
        vecs[3] = '{w: 0, h: 5, vpct: 100, rpct: 100, seqdata: 0, exp_count: 0};
        vecs[4] = '{w: 5, h: 0, vpct: 100, rpct: 100, seqdata: 0, exp_count: 0};
        vecs[5] = '{w: 1, h: 1, vpct: 100, rpct: 100, seqdata: 0, exp_count: 3 * (3 + DR)};
        vecs[6] = '{w: 4, h: 4, vpct: 60,  rpct: 70,  seqdata: 0, exp_count: 6 * (6 + DR)};

        rst = 1'b1; start = 1'b0; cfg_width = '0; cfg_height = '0;
        in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_out_pixel", out_pixel, 64'd0);
        checkOutput("reset_out_last", 64'(out_last), 64'd0);
        checkOutput("reset_in_ready", 64'(in_ready), 64'd0);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_done", 64'(done), 64'd0);
        checkOutput("reset_line_width", 64'(line_width), 64'd0);

        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].w, vecs[i].h, vecs[i].vpct, vecs[i].rpct, vecs[i].seqdata, 0, -1, n);
            checkOutput("vec_count", 64'(n), 64'(vecs[i].exp_count));
        end

        $display("[TB] reset mid-frame after 10 outputs, then full frame");
        applyStimulus(4, 4, 100, 100, 0, 10, -1, n);
        applyStimulus(4, 4, 100, 100, 0, 0, -1, n);
        checkOutput("after_rst_count", 64'(n), 64'(6 * (6 + DR)));

        $display("[TB] start pulse while busy is ignored");
        applyStimulus(3, 3, 80, 80, 0, 0, 6, n);
        checkOutput("restart_count", 64'(n), 64'(5 * (5 + DR)));

        $display("[TB] randomized frames");
        for (int f = 0; f < 12; f++) begin
            rw = $urandom_range(0, 6);
            rh = $urandom_range(0, 5);
            rexp = (rw > 0 && rh > 0) ? (rw + 2) * (rh + 2 + DR) : 0;
            applyStimulus(rw, rh, $urandom_range(30, 100), $urandom_range(30, 100), 0, 0, -1, n);
            checkOutput("rand_count", 64'(n), 64'(rexp));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
